// File: rtl/fcmp_pkg.sv
// rtl/fcmp_pkg.sv - predicate encodings, exception classes and evaluation helpers for fcmp_pipe
package fcmp_pkg;

   typedef enum logic [2:0] {
      OP_EQ  = 3'd0,
      OP_NE  = 3'd1,
      OP_LT  = 3'd2,
      OP_LE  = 3'd3,
      OP_GT  = 3'd4,
      OP_GE  = 3'd5,
      OP_UNO = 3'd6,
      OP_ORD = 3'd7
   } fcmp_op_e;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

   // Coarse ordering across classes: -inf < -normal < zero < +normal < +inf.
   // Zeros ignore the sign so +0 and -0 land on the same rank; NaN is masked later.
   function automatic logic [2:0] fcmp_rank(input logic [1:0] exc, input logic sign);
      logic [2:0] r;
      case (exc)
         EXC_NORMAL: r = sign ? 3'd1 : 3'd3;
         EXC_INF:    r = sign ? 3'd0 : 3'd4;
         default:    r = 3'd2;
      endcase
      return r;
   endfunction

   // Any ordered predicate is false once a NaN is involved; NE and UNO become true.
   function automatic logic fcmp_eval(input fcmp_op_e op, input logic lt, input logic eq,
                                      input logic unord);
      logic r;
      case (op)
         OP_EQ:   r = ~unord & eq;
         OP_NE:   r = unord | ~eq;
         OP_LT:   r = ~unord & lt;
         OP_LE:   r = ~unord & (lt | eq);
         OP_GT:   r = ~unord & ~(lt | eq);
         OP_GE:   r = ~unord & ~lt;
         OP_UNO:  r = unord;
         default: r = ~unord;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fcmp_mag_cmp.sv
// rtl/fcmp_mag_cmp.sv - unsigned magnitude comparator over the packed exponent/fraction field
module fcmp_mag_cmp #(
   parameter int N = 15
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         lt_o,
   output logic         gt_o,
   output logic         eq_o
);

   assign lt_o = (a_i < b_i);
   assign gt_o = (a_i > b_i);
   assign eq_o = ~lt_o & ~gt_o;

endmodule

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - two-stage valid/ready FloPoCo comparator; FCMP_MINMAX_EN adds min_out/max_out
module fcmp_pipe
   import fcmp_pkg::*;
#(
   parameter int WE = 8,
   parameter int WF = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WE+WF+2:0]    X,
   input  logic [WE+WF+2:0]    Y,
   input  logic [2:0]          op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                result,
   output logic                unordered
`ifdef FCMP_MINMAX_EN
   ,
   output logic [WE+WF+2:0]    min_out,
   output logic [WE+WF+2:0]    max_out
`endif
);

   localparam int W  = WE + WF + 3;
   localparam int MW = WE + WF;

   logic          adv1, adv2;
   logic          mag_lt, mag_gt, mag_eq;

   // stage 1 state
   logic          v1_q, v1_d;
   logic [1:0]    exc_x_q, exc_x_d, exc_y_q, exc_y_d;
   logic          sx_q, sx_d, sy_q, sy_d;
   logic          mag_lt_q, mag_lt_d, mag_gt_q, mag_gt_d, mag_eq_q, mag_eq_d;
   fcmp_op_e      op_q, op_d;

   // stage 2 state
   logic          v2_q, v2_d;
   logic          res_q, res_d;
   logic          unord_q, unord_d;

   // stage 2 combine
   logic [2:0]    rank_x, rank_y;
   logic          nan_x, nan_y, ord_lt, ord_eq;

`ifdef FCMP_MINMAX_EN
   logic [W-1:0]  x_q, x_d, y_q, y_d;
   logic [W-1:0]  min_q, min_d, max_q, max_d;
   logic [W-1:0]  mm_min, mm_max;
`endif

   fcmp_mag_cmp #(.N(MW)) u_mag (
      .a_i  (X[MW-1:0]),
      .b_i  (Y[MW-1:0]),
      .lt_o (mag_lt),
      .gt_o (mag_gt),
      .eq_o (mag_eq)
   );

   // Handshake: each stage moves when it is empty or its occupant moves on
   always_comb begin
      adv2 = ~v2_q | out_ready;
      adv1 = ~v1_q | adv2;
   end

   assign in_ready  = adv1;
   assign out_valid = v2_q;
   assign result    = res_q;
   assign unordered = unord_q;

   // Stage 1 next state: decode classes and latch magnitude order when the stage advances
   always_comb begin
      v1_d     = v1_q;
      exc_x_d  = exc_x_q;
      exc_y_d  = exc_y_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      mag_lt_d = mag_lt_q;
      mag_gt_d = mag_gt_q;
      mag_eq_d = mag_eq_q;
      op_d     = op_q;
`ifdef FCMP_MINMAX_EN
      x_d      = x_q;
      y_d      = y_q;
`endif
      if (adv1) begin
         v1_d = in_valid;
         if (in_valid) begin
            exc_x_d  = X[W-1:W-2];
            exc_y_d  = Y[W-1:W-2];
            sx_d     = X[W-3];
            sy_d     = Y[W-3];
            mag_lt_d = mag_lt;
            mag_gt_d = mag_gt;
            mag_eq_d = mag_eq;
            op_d     = fcmp_op_e'(op);
`ifdef FCMP_MINMAX_EN
            x_d      = X;
            y_d      = Y;
`endif
         end
      end
   end

   // Full ordering from class rank; equal-rank normals fall back to magnitude, mirrored for negatives
   always_comb begin
      rank_x = fcmp_rank(exc_x_q, sx_q);
      rank_y = fcmp_rank(exc_y_q, sy_q);
      nan_x  = (exc_x_q == EXC_NAN);
      nan_y  = (exc_y_q == EXC_NAN);
      ord_lt = 1'b0;
      ord_eq = 1'b1;
      if (rank_x != rank_y) begin
         ord_lt = (rank_x < rank_y);
         ord_eq = 1'b0;
      end else if (exc_x_q == EXC_NORMAL) begin
         ord_lt = sx_q ? mag_gt_q : mag_lt_q;
         ord_eq = mag_eq_q;
      end
   end

`ifdef FCMP_MINMAX_EN
   // minNum/maxNum selection: a single NaN defers to the other operand, ties return X
   always_comb begin
      mm_min = x_q;
      mm_max = x_q;
      if (nan_x && nan_y) begin
         mm_min = {EXC_NAN, {(W-2){1'b0}}};
         mm_max = {EXC_NAN, {(W-2){1'b0}}};
      end else if (nan_x) begin
         mm_min = y_q;
         mm_max = y_q;
      end else if (nan_y || ord_eq) begin
         mm_min = x_q;
         mm_max = x_q;
      end else if (ord_lt) begin
         mm_min = x_q;
         mm_max = y_q;
      end else begin
         mm_min = y_q;
         mm_max = x_q;
      end
   end
`endif

   // Stage 2 next state: apply the predicate and capture it when the output slot advances
   always_comb begin
      v2_d    = v2_q;
      res_d   = res_q;
      unord_d = unord_q;
`ifdef FCMP_MINMAX_EN
      min_d   = min_q;
      max_d   = max_q;
`endif
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            res_d   = fcmp_eval(op_q, ord_lt, ord_eq, nan_x | nan_y);
            unord_d = nan_x | nan_y;
`ifdef FCMP_MINMAX_EN
            min_d   = mm_min;
            max_d   = mm_max;
`endif
         end
      end
   end

   // Pipeline registers; reset empties both stages and clears the visible outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         exc_x_q  <= EXC_ZERO;
         exc_y_q  <= EXC_ZERO;
         sx_q     <= 1'b0;
         sy_q     <= 1'b0;
         mag_lt_q <= 1'b0;
         mag_gt_q <= 1'b0;
         mag_eq_q <= 1'b0;
         op_q     <= OP_EQ;
         v2_q     <= 1'b0;
         res_q    <= 1'b0;
         unord_q  <= 1'b0;
`ifdef FCMP_MINMAX_EN
         x_q      <= '0;
         y_q      <= '0;
         min_q    <= '0;
         max_q    <= '0;
`endif
      end else begin
         v1_q     <= v1_d;
         exc_x_q  <= exc_x_d;
         exc_y_q  <= exc_y_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         mag_lt_q <= mag_lt_d;
         mag_gt_q <= mag_gt_d;
         mag_eq_q <= mag_eq_d;
         op_q     <= op_d;
         v2_q     <= v2_d;
         res_q    <= res_d;
         unord_q  <= unord_d;
`ifdef FCMP_MINMAX_EN
         x_q      <= x_d;
         y_q      <= y_d;
         min_q    <= min_d;
         max_q    <= max_d;
`endif
      end
   end

`ifdef FCMP_MINMAX_EN
   assign min_out = min_q;
   assign max_out = max_q;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - scoreboard bench for fcmp_pipe (WE=8, WF=7)
module tb_fcmp_pipe;
   import fcmp_pkg::*;

   localparam int WE = 8;
   localparam int WF = 7;
   localparam int W  = WE + WF + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  X = '0;
   logic [W-1:0]  Y = '0;
   logic [2:0]    op = '0;
   logic          in_ready, out_valid, result, unordered;
`ifdef FCMP_MINMAX_EN
   logic [W-1:0]  min_out, max_out;
`endif

   typedef struct {
      logic         res;
      logic         un;
      logic [W-1:0] mn;
      logic [W-1:0] mx;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t  sb[$];
   exp_t  cur;
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   bit    accepted = 0;
   bit    held = 0;
   bit    lat_mode = 0;
   logic  held_res, held_un;

   fcmp_pipe #(.WE(WE), .WF(WF)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Y         (Y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .unordered (unordered)
`ifdef FCMP_MINMAX_EN
      ,
      .min_out   (min_out),
      .max_out   (max_out)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s,
                                       input logic [7:0] ex, input logic [6:0] f);
      return {e, s, ex, f};
   endfunction

   function automatic bit is_nan(input logic [W-1:0] v);
      return v[W-1:W-2] == 2'b11;
   endfunction

   // Signed ordering key: zero=0, normals 1+expfrac, infinity above every normal
   function automatic longint key(input logic [W-1:0] v);
      longint m;
      case (v[W-1:W-2])
         2'b00:   m = 0;
         2'b01:   m = 1 + longint'(v[W-4:0]);
         default: m = longint'(1) << (W - 2);
      endcase
      return v[W-3] ? -m : m;
   endfunction

   task automatic set_vec(input logic [W-1:0] x, input logic [W-1:0] y, input int o);
      longint kx, ky;
      bit     un;
      X  = x;
      Y  = y;
      op = o[2:0];
      kx = key(x);
      ky = key(y);
      un = is_nan(x) || is_nan(y);
      case (o)
         0:       cur.res = !un && (kx == ky);
         1:       cur.res = un || (kx != ky);
         2:       cur.res = !un && (kx < ky);
         3:       cur.res = !un && (kx <= ky);
         4:       cur.res = !un && (kx > ky);
         5:       cur.res = !un && (kx >= ky);
         6:       cur.res = un;
         default: cur.res = !un;
      endcase
      cur.un = un;
      if (is_nan(x) && is_nan(y)) begin
         cur.mn = {2'b11, {(W-2){1'b0}}};
         cur.mx = {2'b11, {(W-2){1'b0}}};
      end else if (is_nan(x)) begin
         cur.mn = y;
         cur.mx = y;
      end else if (is_nan(y) || kx == ky) begin
         cur.mn = x;
         cur.mx = x;
      end else if (kx < ky) begin
         cur.mn = x;
         cur.mx = y;
      end else begin
         cur.mn = y;
         cur.mx = x;
      end
      cur.lat = lat_mode;
      cur.cyc = 0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      logic [1:0]   e;
      logic         s;
      logic [W-4:0] ef;
      e  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      s  = 1'($urandom_range(0, 1));
      ef = (W-3)'($urandom);
      return {e, s, ef};
   endfunction

   task automatic rnd_vec();
      logic [W-1:0] x, y;
      x = rnd_operand();
      y = ($urandom_range(0, 4) == 0) ? x : rnd_operand();
      set_vec(x, y, int'($urandom_range(0, 7)));
   endtask

   // One clock: check handshake/hold/output at the negedge, then record transfers of the coming edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      accepted = 0;
      if (!rst) begin
         chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
         if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, held_res);
            chk("hold_unordered", unordered, held_un);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("unordered", unordered, e.un);
`ifdef FCMP_MINMAX_EN
               chk("min_out", min_out, e.mn);
               chk("max_out", max_out, e.mx);
`endif
               if (e.lat) chk("latency", 64'(cyc - e.cyc), 2);
            end
         end
         held     = out_valid && !out_ready;
         held_res = result;
         held_un  = unordered;
         accepted = in_valid && in_ready;
         if (accepted) begin
            e     = cur;
            e.cyc = cyc;
            sb.push_back(e);
         end
      end else begin
         held = 0;
      end
      @(posedge clk);
      if (rst) sb.delete();
      cyc++;
      #1;
   endtask

   task automatic dvec(input logic [W-1:0] x, input logic [W-1:0] y, input int o,
                       input logic r, input logic u);
      set_vec(x, y, o);
      cur.res  = r;
      cur.un   = u;
      in_valid = 1'b1;
      tick();
      chk("dir_accept", accepted, 1);
   endtask

   initial begin
      logic [W-1:0] one, two, mone, mtwo, pz, nz, qnan, pinf, ninf;
      int sent;
      bit orp [4];
      one  = mk(2'b01, 1'b0, 8'h7F, 7'h00);
      two  = mk(2'b01, 1'b0, 8'h80, 7'h00);
      mone = mk(2'b01, 1'b1, 8'h7F, 7'h00);
      mtwo = mk(2'b01, 1'b1, 8'h80, 7'h00);
      pz   = mk(2'b00, 1'b0, 8'h00, 7'h00);
      nz   = mk(2'b00, 1'b1, 8'h00, 7'h00);
      qnan = mk(2'b11, 1'b0, 8'h00, 7'h00);
      pinf = mk(2'b10, 1'b0, 8'h00, 7'h00);
      ninf = mk(2'b10, 1'b1, 8'h00, 7'h00);
      orp  = '{1'b1, 1'b0, 1'b0, 1'b1};

      // reset state
      rst = 1'b1;
      out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_unordered", unordered, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef FCMP_MINMAX_EN
      chk("rst_min_out", min_out, 0);
      chk("rst_max_out", max_out, 0);
`endif

      // directed vectors, back to back, latency checked
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      dvec(one,  two,  OP_LT,  1'b1, 1'b0);
      dvec(one,  two,  OP_GE,  1'b0, 1'b0);
      dvec(mtwo, mone, OP_LT,  1'b1, 1'b0);
      dvec(pz,   nz,   OP_EQ,  1'b1, 1'b0);
      dvec(pz,   nz,   OP_LT,  1'b0, 1'b0);
      dvec(qnan, one,  OP_NE,  1'b1, 1'b1);
      dvec(qnan, one,  OP_LE,  1'b0, 1'b1);
      dvec(qnan, one,  OP_UNO, 1'b1, 1'b1);
      dvec(ninf, pinf, OP_LT,  1'b1, 1'b0);
      dvec(pinf, pinf, OP_EQ,  1'b1, 1'b0);
      dvec(pinf, pinf, OP_GT,  1'b0, 1'b0);
      dvec(one,  qnan, OP_ORD, 1'b0, 1'b1);
      dvec(mone, pz,   OP_GT,  1'b0, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("dir_drain", sb.size(), 0);
      lat_mode = 1'b0;

      // random stream under out_ready 1,0,0,1
      sent = 0;
      rnd_vec();
      for (int i = 0; i < 200 && (sent < 8 || sb.size() != 0); i++) begin
         out_ready = orp[i % 4];
         in_valid  = (sent < 8);
         tick();
         if (accepted) begin
            sent++;
            rnd_vec();
         end
      end
      in_valid = 1'b0;
      chk("stream_sent", sent, 8);
      chk("stream_drain", sb.size(), 0);

      // reset with two vectors in flight
      out_ready = 1'b0;
      rnd_vec();
      in_valid = 1'b1;
      tick();
      chk("flush_fill_a", accepted, 1);
      rnd_vec();
      tick();
      chk("flush_fill_b", accepted, 1);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_idle", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
